// File: rtl/triangle_driver.sv
// Issues one handshaken triangle to the engine as a 3-cycle nt/xi/yi burst, then folds the point stream into a bitmap/count.
// done is registered one cycle after busy is seen low; tri_ready is combinational and only high in IDLE with the engine idle.
module triangle_driver #(
  parameter int WAIT_MAX = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tri_valid,
  input  logic [17:0] tri_data,
  output logic        tri_ready,
  input  logic        busy,
  input  logic        po,
  input  logic [2:0]  xo,
  input  logic [2:0]  yo,
  output logic        nt,
  output logic [2:0]  xi,
  output logic [2:0]  yi,
  output logic [63:0] bitmap,
  output logic [6:0]  pt_count,
  output logic        done,
  output logic        timeout,
  output logic        stray
);

  localparam int WW = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_V1,
    S_V2,
    S_V3,
    S_WAIT,
    S_RUN
  } state_t;

  state_t        state_q;
  logic [11:0]   tri_q;
  logic [WW-1:0] wait_q;
  logic          nt_q;
  logic [2:0]    xi_q;
  logic [2:0]    yi_q;
  logic [63:0]   bitmap_q;
  logic [6:0]    pt_count_q;
  logic [6:0]    pt_count_d;
  logic          done_q;
  logic          timeout_q;
  logic          stray_q;

  logic          accept;
  logic          in_capture;

  // Reset gates tri_ready so nothing is accepted while reset is held.
  assign tri_ready  = reset && (state_q == S_IDLE) && !busy;
  assign accept     = tri_valid && tri_ready;
  assign in_capture = (state_q == S_WAIT) || (state_q == S_RUN);
  assign pt_count_d = (pt_count_q == 7'h7F) ? pt_count_q : pt_count_q + 7'd1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      tri_q      <= '0;
      wait_q     <= '0;
      nt_q       <= 1'b0;
      xi_q       <= '0;
      yi_q       <= '0;
      bitmap_q   <= '0;
      pt_count_q <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;

      if (po && !in_capture) stray_q <= 1'b1;

      // Capture runs alongside the state update so a point on the last RUN cycle still lands.
      if (po && in_capture) begin
        bitmap_q[{yo, xo}] <= 1'b1;
        pt_count_q         <= pt_count_d;
      end

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            tri_q      <= tri_data[11:0];
            bitmap_q   <= '0;
            pt_count_q <= '0;
            timeout_q  <= 1'b0;
            nt_q       <= 1'b1;
            xi_q       <= tri_data[17:15];
            yi_q       <= tri_data[14:12];
            state_q    <= S_V1;
          end
        end
        S_V1: begin
          nt_q    <= 1'b0;
          xi_q    <= tri_q[11:9];
          yi_q    <= tri_q[8:6];
          state_q <= S_V2;
        end
        S_V2: begin
          xi_q    <= tri_q[5:3];
          yi_q    <= tri_q[2:0];
          state_q <= S_V3;
        end
        S_V3: begin
          xi_q    <= '0;
          yi_q    <= '0;
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (busy) begin
            state_q <= S_RUN;
          end else if (wait_q == WW'(WAIT_MAX - 1)) begin
            done_q    <= 1'b1;
            timeout_q <= 1'b1;
            state_q   <= S_IDLE;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end
        S_RUN: begin
          if (!busy) begin
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign nt       = nt_q;
  assign xi       = xi_q;
  assign yi       = yi_q;
  assign bitmap   = bitmap_q;
  assign pt_count = pt_count_q;
  assign done     = done_q;
  assign timeout  = timeout_q;
  assign stray    = stray_q;

endmodule

// File: tb/tb_triangle_driver.sv
// Bench for triangle_driver: table of triangles with an engine model and a done-driven scoreboard.
module tb_triangle_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tri_valid = 1'b0;
  logic [17:0] tri_data = '0;
  logic        busy = 1'b0;
  logic        po = 1'b0;
  logic [2:0]  xo = '0;
  logic [2:0]  yo = '0;
  logic        tri_ready;
  logic        nt;
  logic [2:0]  xi;
  logic [2:0]  yi;
  logic [63:0] bitmap;
  logic [6:0]  pt_count;
  logic        done;
  logic        timeout;
  logic        stray;

  triangle_driver #(.WAIT_MAX(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .tri_valid (tri_valid),
    .tri_data  (tri_data),
    .tri_ready (tri_ready),
    .busy      (busy),
    .po        (po),
    .xo        (xo),
    .yo        (yo),
    .nt        (nt),
    .xi        (xi),
    .yi        (yi),
    .bitmap    (bitmap),
    .pt_count  (pt_count),
    .done      (done),
    .timeout   (timeout),
    .stray     (stray)
  );

  always #5 clk = ~clk;

  localparam int NEVER = 255;

  typedef struct {
    logic [17:0] data;
    int          pre_busy;
    int          delay;
    int          npts;
    bit          drop_last;
    int          exp_count;
    bit          exp_to;
  } vec_t;

  typedef struct {
    logic [6:0]  count;
    logic [63:0] bm;
    logic        to;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[6];
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Point i of a triangle's stream, as {y, x}: the three vertices first, then a fixed walk.
  function automatic logic [5:0] pt_of(input logic [17:0] d, input int i);
    logic [2:0] x;
    logic [2:0] y;
    case (i)
      0:       begin x = d[17:15]; y = d[14:12]; end
      1:       begin x = d[11:9];  y = d[8:6];   end
      2:       begin x = d[5:3];   y = d[2:0];   end
      default: begin x = 3'(i * 3); y = 3'(i * 5); end
    endcase
    return {y, x};
  endfunction

  task automatic send(input logic [17:0] d, input int pre_busy);
    int guard;
    @(negedge clk);
    tri_data  = d;
    tri_valid = 1'b1;
    if (pre_busy > 0) begin
      busy = 1'b1;
      repeat (pre_busy) @(negedge clk);
      #1;
      check("ready_low_while_busy", tri_ready, 1'b0);
      check("no_nt_while_busy", nt, 1'b0);
      busy = 1'b0;
      #1;
      check("ready_after_busy_drop", tri_ready, 1'b1);
    end
    #1;
    guard = 0;
    while (!tri_ready && guard < 50) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (!tri_ready) check("accept_bound", 1'b0, 1'b1);
    @(negedge clk);
    tri_valid = 1'b0;
  endtask

  task automatic run_tri(input vec_t v, input string tag);
    exp_t        e;
    exp_t        got;
    logic [63:0] bm;
    logic [5:0]  p;
    int          cyc;
    int          drop_cyc;
    int          exp_done;
    int          done_cyc;

    bm = '0;
    for (int i = 0; i < v.npts; i++) begin
      p = pt_of(v.data, i);
      bm[p] = 1'b1;
    end
    e.count = 7'(v.exp_count);
    e.bm    = bm;
    e.to    = v.exp_to;

    send(v.data, v.pre_busy);
    sb.push_back(e);

    check({tag, "_v1"}, {nt, xi, yi}, {1'b1, v.data[17:12]});
    @(negedge clk);
    check({tag, "_v2"}, {nt, xi, yi}, {1'b0, v.data[11:6]});
    @(negedge clk);
    check({tag, "_v3"}, {nt, xi, yi}, {1'b0, v.data[5:0]});

    cyc = 0;
    if (v.delay == 0) busy = 1'b1;
    drop_cyc = (v.delay == NEVER) ? -1 : v.delay + v.npts + (v.drop_last ? 0 : 1);
    exp_done = (v.delay == NEVER) ? 17 : drop_cyc + 1;
    done_cyc = -1;

    while (done_cyc < 0 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_burst_end"}, {nt, xi, yi}, 7'd0);
        check({tag, "_ready_low"}, tri_ready, 1'b0);
      end
      if (done) begin
        done_cyc = cyc;
      end else if (v.delay != NEVER) begin
        if (cyc == v.delay) busy = 1'b1;
        if (cyc > v.delay && cyc <= v.delay + v.npts) begin
          p  = pt_of(v.data, cyc - v.delay - 1);
          po = 1'b1;
          xo = p[2:0];
          yo = p[5:3];
        end else begin
          po = 1'b0;
        end
        if (cyc == drop_cyc) busy = 1'b0;
      end
    end
    po   = 1'b0;
    busy = 1'b0;

    check({tag, "_done_latency"}, done_cyc, exp_done);
    if (done_cyc > 0) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, 1'b1, 1'b0);
      end else begin
        got = sb.pop_front();
        check({tag, "_pt_count"}, pt_count, got.count);
        check({tag, "_bitmap"}, bitmap, got.bm);
        check({tag, "_timeout"}, timeout, got.to);
      end
    end
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 1'b0);
    check({tag, "_bitmap_hold"}, bitmap, e.bm);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{data: 18'o114114, pre_busy: 0, delay: 0,     npts: 10,  drop_last: 1'b0, exp_count: 10,  exp_to: 1'b0};
    tbl[1] = '{data: 18'o235670, pre_busy: 0, delay: NEVER, npts: 0,   drop_last: 1'b0, exp_count: 0,   exp_to: 1'b1};
    tbl[2] = '{data: 18'o077033, pre_busy: 3, delay: 0,     npts: 4,   drop_last: 1'b1, exp_count: 4,   exp_to: 1'b0};
    tbl[3] = '{data: 18'o326501, pre_busy: 0, delay: 5,     npts: 20,  drop_last: 1'b0, exp_count: 20,  exp_to: 1'b0};
    tbl[4] = '{data: 18'o770052, pre_busy: 0, delay: 1,     npts: 130, drop_last: 1'b1, exp_count: 127, exp_to: 1'b0};
    tbl[5] = '{data: 18'o444444, pre_busy: 0, delay: 16,    npts: 2,   drop_last: 1'b0, exp_count: 2,   exp_to: 1'b0};

    repeat (2) @(negedge clk);
    check("rst_ctrl", {nt, xi, yi, done, timeout, stray, tri_ready}, 11'd0);
    check("rst_bitmap", bitmap, 64'd0);
    check("rst_count", pt_count, 7'd0);
    reset = 1'b1;
    #1;
    check("ready_after_reset", tri_ready, 1'b1);

    @(negedge clk);
    po = 1'b1;
    xo = 3'd5;
    yo = 3'd2;
    @(negedge clk);
    po = 1'b0;
    check("stray_set", stray, 1'b1);
    check("stray_bitmap", bitmap, 64'd0);
    check("stray_count", pt_count, 7'd0);

    for (int r = 0; r < 6; r++) begin
      run_tri(tbl[r], $sformatf("row%0d", r));
      if (r == 0) begin
        check("row0_vertex_bits", {bitmap[33], bitmap[12], bitmap[9]}, 3'b111);
        check("stray_sticky", stray, 1'b1);
      end
    end

    send(18'o523416, 0);
    check("rst_mid_v1", {nt, xi, yi}, {1'b1, 6'o52});
    @(negedge clk);
    check("rst_mid_v2", {nt, xi, yi}, {1'b0, 6'o34});
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_ctrl", {nt, xi, yi, tri_ready}, 8'd0);
    check("rst_mid_bitmap", bitmap, 64'd0);
    check("rst_mid_count", pt_count, 7'd0);
    check("rst_mid_stray", stray, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_mid_idle", tri_ready, 1'b1);
    run_tri(tbl[0], "after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
